// File: rtl/register_file.sv
// Two-read, one-write general-purpose register file; entry 0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  write_ok;

    assign write_ok = reg_write && (write_reg != '0);

    // Storage: cleared asynchronously, one write per edge, entry 0 never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[write_reg] <= write_data;
        end
    end

    // Read port 1: zero for index 0, optional same-cycle forwarding.
    always_comb begin
        read_data1 = (read_reg1 == '0) ? '0 : regs[read_reg1];
`ifdef REGFILE_BYPASS_EN
        if (write_ok && rst_n && (write_reg == read_reg1)) begin
            read_data1 = write_data;
        end
`endif
    end

    // Read port 2: same rules as port 1, checked independently.
    always_comb begin
        read_data2 = (read_reg2 == '0) ? '0 : regs[read_reg2];
`ifdef REGFILE_BYPASS_EN
        if (write_ok && rst_n && (write_reg == read_reg2)) begin
            read_data2 = write_data;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Directed plus randomized bench for register_file against an array model.
// Follows REGFILE_BYPASS_EN the same way the design does.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int n_checks;
    int n_fail;

    logic [31:0] model [32];

    register_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .read_reg1 (read_reg1),
        .read_reg2 (read_reg2),
        .write_reg (write_reg),
        .write_data(write_data),
        .reg_write (reg_write),
        .read_data1(read_data1),
        .read_data2(read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // What a read of idx should show right now, given the driven inputs.
    function automatic logic [31:0] expect_read(input logic [4:0] idx);
        logic [31:0] v;
        if (!rst_n || idx == 5'd0) return 32'h0;
        v = model[idx];
`ifdef REGFILE_BYPASS_EN
        if (reg_write && write_reg == idx) v = write_data;
`endif
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // One full access: drive after negedge, check reads, then take the edge.
    task automatic cycle(input logic we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic [4:0] r1,
                         input logic [4:0] r2, input string tag);
        @(negedge clk);
        reg_write  = we;
        write_reg  = wr;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        #1;
        chk({tag, "_rd1"}, read_data1, expect_read(r1));
        chk({tag, "_rd2"}, read_data2, expect_read(r2));
        @(posedge clk);
        if (rst_n && we && wr != 5'd0) model[wr] = wd;
        #1;
    endtask

    // Idle cycle that only reads, checking against literal expectations.
    task automatic read_pair(input logic [4:0] r1, input logic [4:0] r2,
                             input logic [31:0] e1, input logic [31:0] e2,
                             input string tag);
        @(negedge clk);
        reg_write = 1'b0;
        read_reg1 = r1;
        read_reg2 = r2;
        #1;
        chk({tag, "_rd1"}, read_data1, e1);
        chk({tag, "_rd2"}, read_data2, e2);
    endtask

    initial begin
        logic        we;
        logic [4:0]  wr;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] wd;

        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        reg_write  = 1'b0;
        write_reg  = 5'd0;
        write_data = 32'h0;
        read_reg1  = 5'd0;
        read_reg2  = 5'd31;
        clear_model();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_r0", read_data1, 32'h0);
        chk("reset_r31", read_data2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload, then pull reset mid-cycle with no clock edge.
        cycle(1'b1, 5'd1, 32'hA5A5_0001, 5'd0, 5'd0, "pre1");
        cycle(1'b1, 5'd31, 32'hA5A5_001F, 5'd0, 5'd0, "pre31");
        read_pair(5'd1, 5'd31, 32'hA5A5_0001, 32'hA5A5_001F, "preload");
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_r1", read_data1, 32'h0);
        chk("async_rst_r31", read_data2, 32'h0);
        read_reg1 = 5'd0;
        #1;
        chk("async_rst_r0", read_data1, 32'h0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;

        // Plain writes on successive edges.
        cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, "w5");
        cycle(1'b1, 5'd31, 32'h0000_0007, 5'd0, 5'd0, "w31");
        read_pair(5'd5, 5'd31, 32'hDEAD_BEEF, 32'h0000_0007, "wr_rd");
        read_pair(5'd31, 5'd31, 32'h0000_0007, 32'h0000_0007, "same_idx");

        // Writes to r0 are dropped.
        cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "w0");
        read_pair(5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF, "r0_prot");

        // Write enable low leaves storage alone.
        cycle(1'b1, 5'd9, 32'h0000_AAAA, 5'd0, 5'd0, "w9");
        cycle(1'b0, 5'd9, 32'h1234_5678, 5'd9, 5'd9, "we_off");
        read_pair(5'd9, 5'd0, 32'h0000_AAAA, 32'h0, "we_gate");

        // Same-cycle read of the entry being written.
        cycle(1'b1, 5'd3, 32'h1111_1111, 5'd0, 5'd0, "w3a");
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd3;
        write_data = 32'h2222_2222;
        read_reg1  = 5'd3;
        read_reg2  = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("rw_pre_rd1", read_data1, 32'h2222_2222);
        chk("rw_pre_rd2", read_data2, 32'h2222_2222);
`else
        chk("rw_pre_rd1", read_data1, 32'h1111_1111);
        chk("rw_pre_rd2", read_data2, 32'h1111_1111);
`endif
        @(posedge clk);
        model[3] = 32'h2222_2222;
        read_pair(5'd3, 5'd3, 32'h2222_2222, 32'h2222_2222, "rw_post");

        // Reset falling on the same edge as a write to r4.
        cycle(1'b1, 5'd4, 32'h0000_0009, 5'd0, 5'd0, "w4a");
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd4;
        write_data = 32'h0000_0005;
        @(posedge clk);
        rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        reg_write = 1'b0;
        rst_n     = 1'b1;
        read_pair(5'd4, 5'd4, 32'h0, 32'h0, "rst_mid_wr");

        // Randomized traffic against the array model.
        for (int n = 0; n < 400; n++) begin
            we = ($urandom_range(0, 3) != 0);
            wr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) wr = 5'd0;
            wd = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            cycle(we, wr, wd, r1, r2, "rand");
        end

        // Final sweep of every entry.
        for (int i = 0; i < 32; i++) begin
            read_pair(5'(i), 5'(31 - i), (i == 0) ? 32'h0 : model[i],
                      (i == 31) ? 32'h0 : model[31 - i], "sweep");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
